// File: rtl/scramble_sequencer.sv
// Cube scramble generator: LFSR-driven move candidates, rejection sampling and a valid/ready move stream.
// Optional macro SCR_AXIS_CANON_EN also rejects descending moves on the previous move's axis.
module scramble_sequencer #(
    parameter int                  LFSR_W = 16,
    parameter logic [LFSR_W-1:0]   TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0]   SEED   = 16'hACE1,
    parameter int                  LEN_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  length_i,
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_in_i,
    output logic              move_valid_o,
    input  logic              move_ready_i,
    output logic [2:0]        move_face_o,
    output logic [1:0]        move_rot_o,
    output logic              move_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [LFSR_W-1:0] lfsr_q_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LFSR_W-1:0] LFSR_ZERO = {LFSR_W{1'b0}};

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & TAPS)};
    endfunction

    state_t             state_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [LEN_W-1:0]   count_q;
    logic [LEN_W-1:0]   len_q;
    logic [2:0]         prev_face_q;
    logic               prev_valid_q;
    logic               move_valid_q;
    logic [2:0]         move_face_q;
    logic [1:0]         move_rot_q;
    logic               move_last_q;
    logic               busy_q;
    logic               done_q;

    logic [LFSR_W-1:0]  lfsr_step_d;
    logic [LFSR_W-1:0]  seed_d;
    logic [2:0]         cand_face_s;
    logic [1:0]         cand_rot_s;
    logic               reject_s;
    logic               is_last_s;

    // Candidate move decoded from the pre-step LFSR and the next LFSR value.
    always_comb begin
        lfsr_step_d = lfsr_step(lfsr_q);
        cand_face_s = lfsr_q[2:0];
        cand_rot_s  = lfsr_q[4:3];
        is_last_s   = (count_q == (len_q - LEN_ONE));
        if (seed_in_i == LFSR_ZERO) begin
            seed_d = SEED;
        end else begin
            seed_d = seed_in_i;
        end
    end

    // Rejection rules; out-of-range codes are discarded rather than folded to keep moves uniform.
    always_comb begin
        reject_s = 1'b0;
        if (cand_face_s >= 3'd6) begin
            reject_s = 1'b1;
        end else if (cand_rot_s == 2'd3) begin
            reject_s = 1'b1;
        end else if (prev_valid_q && (cand_face_s == prev_face_q)) begin
            reject_s = 1'b1;
`ifdef SCR_AXIS_CANON_EN
        end else if (prev_valid_q && (cand_face_s[2:1] == prev_face_q[2:1])
                     && (cand_face_s < prev_face_q)) begin
            reject_s = 1'b1;
`endif
        end else begin
            reject_s = 1'b0;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= SEED;
            count_q      <= LEN_ZERO;
            len_q        <= LEN_ZERO;
            prev_face_q  <= 3'd0;
            prev_valid_q <= 1'b0;
            move_valid_q <= 1'b0;
            move_face_q  <= 3'd0;
            move_rot_q   <= 2'd0;
            move_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A seed load wins over a simultaneous start.
                    if (seed_load_i) begin
                        lfsr_q <= seed_d;
                    end else if (start_i) begin
                        if (length_i != LEN_ZERO) begin
                            state_q      <= ST_GEN;
                            count_q      <= LEN_ZERO;
                            len_q        <= length_i;
                            prev_valid_q <= 1'b0;
                            busy_q       <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GEN: begin
                    lfsr_q <= lfsr_step_d;
                    if (!reject_s) begin
                        move_face_q  <= cand_face_s;
                        move_rot_q   <= cand_rot_s;
                        move_valid_q <= 1'b1;
                        move_last_q  <= is_last_s;
                        state_q      <= ST_OUT;
                    end else begin
                        state_q <= ST_GEN;
                    end
                end
                ST_OUT: begin
                    if (move_ready_i) begin
                        move_valid_q <= 1'b0;
                        move_last_q  <= 1'b0;
                        count_q      <= count_q + LEN_ONE;
                        prev_face_q  <= move_face_q;
                        prev_valid_q <= 1'b1;
                        if (move_last_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_GEN;
                        end
                    end else begin
                        state_q <= ST_OUT;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    move_valid_q <= 1'b0;
                    move_last_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign move_valid_o = move_valid_q;
    assign move_face_o  = move_face_q;
    assign move_rot_o   = move_rot_q;
    assign move_last_o  = move_last_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign lfsr_q_o     = lfsr_q;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Directed bench for scramble_sequencer: a reference LFSR model fills a move scoreboard that is
// drained against the DUT's handshakes.
module tb_scramble_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [5:0]  length_i;
    logic        seed_load_i;
    logic [15:0] seed_in_i;
    logic        move_valid_o;
    logic        move_ready_i;
    logic [2:0]  move_face_o;
    logic [1:0]  move_rot_o;
    logic        move_last_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] lfsr_q_o;

    scramble_sequencer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .length_i     (length_i),
        .seed_load_i  (seed_load_i),
        .seed_in_i    (seed_in_i),
        .move_valid_o (move_valid_o),
        .move_ready_i (move_ready_i),
        .move_face_o  (move_face_o),
        .move_rot_o   (move_rot_o),
        .move_last_o  (move_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .lfsr_q_o     (lfsr_q_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  f;
        logic [1:0]  r;
        logic        last;
        int          cyc;
        logic [15:0] lf;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_lfsr;
    logic [2:0]  obs_face;
    logic [1:0]  obs_rot;
    logic [15:0] obs_lfsr;
    int          obs_cyc;
    int          hs_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: taps 15,13,12,10 for mask 16'hB400.
    function automatic void gen_move(inout logic [15:0] l, input logic [2:0] pf, input bit pfv,
                                     output logic [2:0] f, output logic [1:0] r, output int cyc);
        bit   ok;
        logic fb;
        ok = 1'b0; cyc = 0; f = 3'd0; r = 2'd0;
        while (!ok && cyc < 1000) begin
            f  = l[2:0];
            r  = l[4:3];
            ok = (f < 3'd6) && (r != 2'd3) && !(pfv && (f == pf));
            fb = l[15] ^ l[13] ^ l[12] ^ l[10];
            l  = {l[14:0], fb};
            cyc++;
        end
    endfunction

    task automatic load_seed(input logic [15:0] s);
        seed_load_i = 1'b1;
        seed_in_i   = s;
        @(negedge clk_i);
        seed_load_i = 1'b0;
        m_lfsr = (s == 16'h0000) ? 16'hACE1 : s;
    endtask

    task automatic run_scramble(input int len, input bit stall_en);
        exp_t       e;
        logic [2:0] pf, ef;
        logic [1:0] er;
        int         ec, w, nst;
        bit         pfv;
        logic [5:0] snap;
        pf = 3'd0; pfv = 1'b0; hs_count = 0;
        for (int k = 0; k < len; k++) begin
            gen_move(m_lfsr, pf, pfv, ef, er, ec);
            e.f = ef; e.r = er; e.cyc = ec; e.lf = m_lfsr; e.last = (k == len - 1);
            sb.push_back(e);
            pf = ef; pfv = 1'b1;
        end
        start_i  = 1'b1;
        length_i = len[5:0];
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
        pfv = 1'b0;
        for (int k = 0; k < len; k++) begin
            w = 0;
            while (move_valid_o !== 1'b1 && w < 200) begin
                if (stall_en) move_ready_i = 1'($urandom_range(0, 1));
                @(negedge clk_i);
                w++;
            end
            move_ready_i = 1'b0;
            if (move_valid_o !== 1'b1) begin
                chk("valid_timeout", 32'(move_valid_o), 32'd1);
                sb.delete();
                return;
            end
            e = sb.pop_front();
            chk("gen_cycles", 32'(w), 32'(e.cyc));
            chk("move_face", 32'(move_face_o), 32'(e.f));
            chk("move_rot", 32'(move_rot_o), 32'(e.r));
            chk("move_last", 32'(move_last_o), 32'(e.last));
            chk("lfsr_after_accept", 32'(lfsr_q_o), 32'(e.lf));
            chk("face_range", 32'(move_face_o < 3'd6), 32'd1);
            chk("rot_range", 32'(move_rot_o < 2'd3), 32'd1);
            if (pfv) chk("face_repeat", 32'(move_face_o != pf), 32'd1);
            obs_face = move_face_o; obs_rot = move_rot_o; obs_lfsr = lfsr_q_o; obs_cyc = w;
            snap = {move_valid_o, move_face_o, move_rot_o};
            nst = stall_en ? $urandom_range(0, 3) : 0;
            for (int s = 0; s < nst; s++) begin
                @(negedge clk_i);
                chk("stall_stable", 32'({move_valid_o, move_face_o, move_rot_o}), 32'(snap));
                chk("stall_last", 32'(move_last_o), 32'(e.last));
                chk("stall_lfsr_frozen", 32'(lfsr_q_o), 32'(e.lf));
            end
            move_ready_i = 1'b1;
            @(negedge clk_i);
            move_ready_i = 1'b0;
            hs_count++;
            pf = obs_face; pfv = 1'b1;
            chk("valid_drop", 32'(move_valid_o), 32'd0);
            chk("done_on_hs", 32'(done_o), 32'(e.last));
            chk("busy_on_hs", 32'(busy_o), 32'(!e.last));
            if (e.last) begin
                @(negedge clk_i);
                chk("done_single", 32'(done_o), 32'd0);
            end
        end
    endtask

    initial begin
        int w;
        rst_ni = 1'b0; start_i = 1'b0; length_i = 6'd0; seed_load_i = 1'b0;
        seed_in_i = 16'h0000; move_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_lfsr", 32'(lfsr_q_o), 32'h0000ACE1);
        chk("rst_valid", 32'(move_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_face_rot", 32'({move_face_o, move_rot_o}), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        m_lfsr = 16'hACE1;

        load_seed(16'h0001);
        chk("seed_0001", 32'(lfsr_q_o), 32'h00000001);
        run_scramble(1, 1'b0);
        chk("s1_face", 32'(obs_face), 32'd1);
        chk("s1_rot", 32'(obs_rot), 32'd0);
        chk("s1_lfsr", 32'(obs_lfsr), 32'h00000002);

        load_seed(16'h0007);
        chk("seed_0007", 32'(lfsr_q_o), 32'h00000007);
        run_scramble(1, 1'b0);
        chk("s7_face", 32'(obs_face), 32'd0);
        chk("s7_rot", 32'(obs_rot), 32'd2);
        chk("s7_cycles", 32'(obs_cyc), 32'd5);
        chk("s7_lfsr", 32'(obs_lfsr), 32'h000000E0);

        start_i = 1'b1; length_i = 6'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("len0_done", 32'(done_o), 32'd1);
        chk("len0_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        chk("len0_done_single", 32'(done_o), 32'd0);
        chk("len0_lfsr_idle", 32'(lfsr_q_o), 32'h000000E0);

        load_seed(16'h0000);
        chk("seed_zero_subst", 32'(lfsr_q_o), 32'h0000ACE1);

        seed_load_i = 1'b1; seed_in_i = 16'h1234; start_i = 1'b1; length_i = 6'd3;
        @(negedge clk_i);
        seed_load_i = 1'b0; start_i = 1'b0; m_lfsr = 16'h1234;
        chk("seed_beats_start_lfsr", 32'(lfsr_q_o), 32'h00001234);
        chk("seed_beats_start_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        chk("seed_beats_start_idle", 32'({busy_o, move_valid_o}), 32'd0);

        run_scramble(63, 1'b1);
        chk("handshakes_63", 32'(hs_count), 32'd63);

        start_i = 1'b1; length_i = 6'd5;
        @(negedge clk_i);
        start_i = 1'b0;
        w = 0;
        while (move_valid_o !== 1'b1 && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        chk("abort_valid_before", 32'(move_valid_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("abort_valid", 32'(move_valid_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_lfsr", 32'(lfsr_q_o), 32'h0000ACE1);
        chk("abort_outs", 32'({move_face_o, move_rot_o, move_last_o, done_o}), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("abort_no_done", 32'({done_o, busy_o}), 32'd0);
        end
        run_scramble(3, 1'b1);
        chk("post_abort_handshakes", 32'(hs_count), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
